// File: rtl/axis_width_pkg.sv
// Shared sizing helpers for the AXI4-Stream width converters.
//   lane_w(s_width, ratio) : bits needed for a lane index 0..ratio-1
//   keep_w(w)              : TKEEP width for a TDATA width of w bits
//   lane_cnt_t             : generic lane index type; it is wide enough for ratios up to 256
package axis_width_pkg;

  localparam int LANE_CNT_MAX_W = 8;

  typedef logic [LANE_CNT_MAX_W-1:0] lane_cnt_t;

  // A ratio of 1 would give $clog2 = 0, so the result is floored at 1 bit.
  function automatic int lane_w(input int s_width, input int ratio);
    return (s_width > 0 && ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  function automatic int keep_w(input int w);
    return w / 8;
  endfunction

endpackage

// File: rtl/axis_upsize_pack.sv
// Pack stage of the packet-aware upsizer.
// It holds the lane counter and the pack data/keep/last registers, and it detects the closing beat.
// It also presents the wide beat that the current slave transfer would complete.
//   aclk, aresetn        clock, synchronous active-low reset
//   s_fire               a slave transfer happens this cycle
//   s_data/s_keep/s_last narrow beat being transferred
//   close                this transfer closes a wide beat (last lane or tlast)
//   wide_data/keep/last  wide beat including this transfer; lanes above it are zero
//   pack_data/keep/last  registered pack contents; this is a full wide beat after a close
module axis_upsize_pack
  import axis_width_pkg::*;
#(
  parameter int S_WIDTH = 32,
  parameter int RATIO   = 2
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic                                s_fire,
  input  logic [S_WIDTH-1:0]                  s_data,
  input  logic [keep_w(S_WIDTH)-1:0]          s_keep,
  input  logic                                s_last,
  output logic                                close,
  output logic [S_WIDTH*RATIO-1:0]            wide_data,
  output logic [keep_w(S_WIDTH*RATIO)-1:0]    wide_keep,
  output logic                                wide_last,
  output logic [S_WIDTH*RATIO-1:0]            pack_data,
  output logic [keep_w(S_WIDTH*RATIO)-1:0]    pack_keep,
  output logic                                pack_last
);

  localparam int LANE_W = lane_w(S_WIDTH, RATIO);
  localparam int SK_W   = keep_w(S_WIDTH);

  typedef logic [LANE_W-1:0] lane_t;

  lane_t     lane;
  lane_cnt_t lane_ext;

  assign lane_ext = lane_cnt_t'(lane);
  assign close    = s_fire && ((lane == lane_t'(RATIO - 1)) || s_last);

  // Lanes below the current one come from the pack register and the current lane comes from the slave.
  // Lanes above are forced to zero. Stale lanes left over from an earlier packet therefore never leak out.
  always_comb begin
    wide_data = '0;
    wide_keep = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (lane_cnt_t'(k) < lane_ext) begin
        wide_data[k*S_WIDTH +: S_WIDTH] = pack_data[k*S_WIDTH +: S_WIDTH];
        wide_keep[k*SK_W +: SK_W]       = pack_keep[k*SK_W +: SK_W];
      end else if (lane_cnt_t'(k) == lane_ext) begin
        wide_data[k*S_WIDTH +: S_WIDTH] = s_data;
        wide_keep[k*SK_W +: SK_W]       = s_keep;
      end
    end
    wide_last = s_last;
  end

  // Loading the whole composed beat on every transfer writes the new lane.
  // On a close, it also leaves a complete wide beat behind, which is what the top reads while pack_full.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      lane      <= '0;
      pack_data <= '0;
      pack_keep <= '0;
      pack_last <= 1'b0;
    end else if (s_fire) begin
      pack_data <= wide_data;
      pack_keep <= wide_keep;
      pack_last <= wide_last;
      lane      <= close ? '0 : lane + lane_t'(1);
    end
  end

endmodule

// File: rtl/axis_dwidth_upsize_pkt.sv
// Packet-aware AXI4-Stream width upsizer.
// It packs RATIO narrow beats into one wide beat, with lane 0 in the LSBs.
// A partial wide beat is flushed on TLAST.
// The design has two registers, the pack register and the output register.
// This sustains one slave beat per cycle while m_axis_tready stays high.
//   aclk, aresetn            clock, synchronous active-low reset
//   s_axis_tvalid/tready     slave handshake
//   s_axis_tdata/tkeep/tlast slave beat (S_WIDTH bits)
//   m_axis_tvalid/tready     master handshake
//   m_axis_tdata/tkeep/tlast master beat (M_WIDTH = S_WIDTH*RATIO bits)
module axis_dwidth_upsize_pkt
  import axis_width_pkg::*;
#(
  parameter  int S_WIDTH = 32,
  parameter  int RATIO   = 2,
  localparam int M_WIDTH = S_WIDTH * RATIO
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [S_WIDTH-1:0]          s_axis_tdata,
  input  logic [keep_w(S_WIDTH)-1:0]  s_axis_tkeep,
  input  logic                        s_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [M_WIDTH-1:0]          m_axis_tdata,
  output logic [keep_w(M_WIDTH)-1:0]  m_axis_tkeep,
  output logic                        m_axis_tlast
);

  localparam int MK_W = keep_w(M_WIDTH);

  logic               aresetn_q;
  logic               pack_full;
  logic               s_fire;
  logic               close;
  logic               out_free;
  logic [M_WIDTH-1:0] wide_data;
  logic [MK_W-1:0]    wide_keep;
  logic               wide_last;
  logic [M_WIDTH-1:0] pack_data;
  logic [MK_W-1:0]    pack_keep;
  logic               pack_last;

  // Ready comes only from registered state. It holds low through reset and while a finished wide beat waits.
  assign s_axis_tready = aresetn_q && !pack_full;
  assign s_fire        = s_axis_tvalid && s_axis_tready;
  assign out_free      = !m_axis_tvalid || m_axis_tready;

  axis_upsize_pack #(
    .S_WIDTH (S_WIDTH),
    .RATIO   (RATIO)
  ) u_pack (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .s_fire    (s_fire),
    .s_data    (s_axis_tdata),
    .s_keep    (s_axis_tkeep),
    .s_last    (s_axis_tlast),
    .close     (close),
    .wide_data (wide_data),
    .wide_keep (wide_keep),
    .wide_last (wide_last),
    .pack_data (pack_data),
    .pack_keep (pack_keep),
    .pack_last (pack_last)
  );

  // pack_full is only ever set while the output holds a beat, so it implies m_axis_tvalid=1.
  // While it is set no slave beat is accepted, so close cannot fire in the same cycle.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aresetn_q     <= 1'b0;
      pack_full     <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      aresetn_q <= 1'b1;
      if (pack_full) begin
        if (m_axis_tready) begin
          m_axis_tdata <= pack_data;
          m_axis_tkeep <= pack_keep;
          m_axis_tlast <= pack_last;
          pack_full    <= 1'b0;
        end
      end else if (close) begin
        if (out_free) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= wide_data;
          m_axis_tkeep  <= wide_keep;
          m_axis_tlast  <= wide_last;
        end else begin
          pack_full <= 1'b1;
        end
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_dwidth_upsize_pkt.sv
module tb_axis_dwidth_upsize_pkt;

  logic        aclk = 1'b0;
  logic        aresetn;

  logic        s_valid, s_ready, s_last, m_valid, m_ready, m_last;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic [63:0] m_data;
  logic [7:0]  m_keep;

  logic        b_s_valid, b_s_ready, b_s_last, b_m_valid, b_m_ready, b_m_last;
  logic [7:0]  b_s_data;
  logic [0:0]  b_s_keep;
  logic [31:0] b_m_data;
  logic [3:0]  b_m_keep;

  always #5 aclk = ~aclk;

  axis_dwidth_upsize_pkt #(.S_WIDTH(32), .RATIO(2)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tdata(s_data),
    .s_axis_tkeep(s_keep), .s_axis_tlast(s_last),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tdata(m_data),
    .m_axis_tkeep(m_keep), .m_axis_tlast(m_last)
  );

  axis_dwidth_upsize_pkt #(.S_WIDTH(8), .RATIO(4)) dut8 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(b_s_valid), .s_axis_tready(b_s_ready), .s_axis_tdata(b_s_data),
    .s_axis_tkeep(b_s_keep), .s_axis_tlast(b_s_last),
    .m_axis_tvalid(b_m_valid), .m_axis_tready(b_m_ready), .m_axis_tdata(b_m_data),
    .m_axis_tkeep(b_m_keep), .m_axis_tlast(b_m_last)
  );

  typedef struct packed {logic [63:0] d; logic [7:0] k; logic l;} wbeat_t;
  typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} sbeat_t;
  typedef struct {
    logic [31:0] d; logic [3:0] k; logic l;
    logic eo; logic [63:0] ed; logic [7:0] ek; logic el;
  } vec_t;

  int     checks = 0;
  int     failures = 0;
  wbeat_t got_q[$];
  wbeat_t exp_q[$];
  sbeat_t src[$];
  vec_t   vecs[11];

  int          idx, notready, vpat, stab_err, sent, lane;
  logic        acc, hold, hl, exp_v;
  logic [63:0] hd, wd;
  logic [7:0]  hk, wk;
  sbeat_t      sb;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  always @(posedge aclk) begin
    if (m_valid && m_ready) got_q.push_back({m_data, m_keep, m_last});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          data          keep  last  out   exp data                 keep   last
    vecs[0]  = '{32'h1,        4'hF, 1'b0, 1'b0, 64'h0,                   8'h00, 1'b0};
    vecs[1]  = '{32'h2,        4'hF, 1'b0, 1'b1, 64'h00000002_00000001,   8'hFF, 1'b0};
    vecs[2]  = '{32'h3,        4'hF, 1'b0, 1'b0, 64'h0,                   8'h00, 1'b0};
    vecs[3]  = '{32'h4,        4'hF, 1'b1, 1'b1, 64'h00000004_00000003,   8'hFF, 1'b1};
    vecs[4]  = '{32'hA,        4'hF, 1'b1, 1'b1, 64'h00000000_0000000A,   8'h0F, 1'b1};
    vecs[5]  = '{32'hDEADBEEF, 4'h0, 1'b0, 1'b0, 64'h0,                   8'h00, 1'b0};
    vecs[6]  = '{32'hCAFEF00D, 4'h3, 1'b1, 1'b1, 64'hCAFEF00D_DEADBEEF,   8'h30, 1'b1};
    vecs[7]  = '{32'h12345678, 4'hF, 1'b0, 1'b0, 64'h0,                   8'h00, 1'b0};
    vecs[8]  = '{32'h9ABCDEF0, 4'h1, 1'b1, 1'b1, 64'h9ABCDEF0_12345678,   8'h1F, 1'b1};
    vecs[9]  = '{32'hFFFFFFFF, 4'hF, 1'b0, 1'b0, 64'h0,                   8'h00, 1'b0};
    vecs[10] = '{32'h00000055, 4'h1, 1'b1, 1'b0, 64'h0,                   8'h00, 1'b0};

    aresetn = 1'b0; m_ready = 1'b1; b_m_ready = 1'b1;
    s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
    b_s_valid = 1'b0; b_s_data = '0; b_s_keep = '0; b_s_last = 1'b0;
    repeat (3) tick();
    chk("reset_m_valid", m_valid, 1'b0);
    chk("reset_m_data", m_data, 64'h0);
    chk("reset_m_keep", m_keep, 8'h0);
    chk("reset_m_last", m_last, 1'b0);
    chk("reset_s_ready", s_ready, 1'b0);
    aresetn = 1'b1;
    tick();
    chk("release_s_ready", s_ready, 1'b1);
    chk("release_s_ready8", b_s_ready, 1'b1);

    // Table: one slave beat per cycle with m_ready=1, so every close is visible one cycle later.
    // vecs[9] is followed by a lane-0 tlast beat whose lane 1 must read zero.
    vecs[10].eo = 1'b1; vecs[10].ed = 64'h00000000_00000055; vecs[10].ek = 8'h01; vecs[10].el = 1'b1;
    vecs[9].eo  = 1'b0;
    for (int i = 0; i < 11; i++) begin
      s_valid = 1'b1; s_data = vecs[i].d; s_keep = vecs[i].k; s_last = vecs[i].l;
      if (i == 10) begin
        // Insert a second lane so the lane-0 tlast beat follows a completed full beat with stale lane 1.
        s_data = 32'hEEEEEEEE; s_keep = 4'hF; s_last = 1'b0;
        tick();
        chk("vec_fill_valid", m_valid, 1'b1);
        chk("vec_fill_data", m_data, 64'hEEEEEEEE_FFFFFFFF);
        s_data = vecs[i].d; s_keep = vecs[i].k; s_last = vecs[i].l;
      end
      tick();
      chk($sformatf("vec%0d_valid", i), m_valid, vecs[i].eo);
      if (vecs[i].eo) begin
        chk($sformatf("vec%0d_data", i), m_data, vecs[i].ed);
        chk($sformatf("vec%0d_keep", i), m_keep, vecs[i].ek);
        chk($sformatf("vec%0d_last", i), m_last, vecs[i].el);
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    tick();

    // Backpressure: with m_ready=0 exactly four beats fit, then the beats drain in order.
    got_q.delete();
    m_ready = 1'b0; idx = 0;
    for (int c = 0; c < 10; c++) begin
      s_valid = 1'b1; s_data = 32'h10 + idx; s_keep = 4'hF; s_last = 1'b0;
      acc = s_ready;
      tick();
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 4);
    chk("bp_s_ready", s_ready, 1'b0);
    chk("bp_m_valid", m_valid, 1'b1);
    chk("bp_hold_data", m_data, 64'h00000011_00000010);
    stab_err = 0;
    repeat (3) begin
      tick();
      if (m_valid !== 1'b1 || m_data !== 64'h00000011_00000010) stab_err++;
    end
    chk("bp_stable", stab_err, 0);
    m_ready = 1'b1;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      s_data = 32'h10 + idx;
      acc = s_ready;
      tick();
      if (acc) idx++;
    end
    s_valid = 1'b0;
    repeat (4) tick();
    chk("bp_count", got_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < got_q.size())
        chk($sformatf("bp_beat%0d", k), got_q[k], {32'(17 + 2*k), 32'(16 + 2*k), 8'hFF, 1'b0});
    end

    // Throughput: 16 back-to-back beats give a master beat every other cycle.
    got_q.delete();
    m_ready = 1'b1; notready = 0; vpat = 0;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 32'h100 + i; s_keep = 4'hF; s_last = 1'b0;
      if (s_ready !== 1'b1) notready++;
      tick();
      exp_v = (i % 2) == 1;
      if (m_valid !== exp_v) vpat++;
    end
    s_valid = 1'b0;
    tick();
    chk("tp_s_ready", notready, 0);
    chk("tp_valid_pattern", vpat, 0);
    chk("tp_count", got_q.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < got_q.size())
        chk($sformatf("tp_beat%0d", k), got_q[k].d, {32'(257 + 2*k), 32'(256 + 2*k)});
    end

    // Reset with a partial pack: 0x55 must never appear.
    got_q.delete();
    s_valid = 1'b1; s_data = 32'h55; s_keep = 4'hF; s_last = 1'b0;
    tick();
    s_valid = 1'b0;
    aresetn = 1'b0;
    tick();
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 64'h0);
    chk("rst_m_keep", m_keep, 8'h0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_s_ready", s_ready, 1'b0);
    aresetn = 1'b1;
    tick();
    chk("rst_release_ready", s_ready, 1'b1);
    s_valid = 1'b1; s_data = 32'h66;
    tick();
    s_data = 32'h77;
    tick();
    s_valid = 1'b0;
    tick();
    chk("rst_count", got_q.size(), 1);
    if (got_q.size() > 0) chk("rst_beat", got_q[0], {64'h00000077_00000066, 8'hFF, 1'b0});

    // 8-bit, 4:1 instance.
    b_m_ready = 1'b1;
    b_s_valid = 1'b1; b_s_keep = 1'b1;
    b_s_data = 8'h11; b_s_last = 1'b0; tick();
    b_s_data = 8'h22; tick();
    b_s_data = 8'h33; b_s_last = 1'b1; tick();
    chk("w8_short_valid", b_m_valid, 1'b1);
    chk("w8_short_data", b_m_data, 32'h00332211);
    chk("w8_short_keep", b_m_keep, 4'h7);
    chk("w8_short_last", b_m_last, 1'b1);
    b_s_data = 8'h11; b_s_last = 1'b0; tick();
    chk("w8_mid_valid", b_m_valid, 1'b0);
    b_s_data = 8'h22; tick();
    b_s_data = 8'h33; tick();
    b_s_data = 8'h44; tick();
    b_s_valid = 1'b0;
    chk("w8_full_valid", b_m_valid, 1'b1);
    chk("w8_full_data", b_m_data, 32'h44332211);
    chk("w8_full_keep", b_m_keep, 4'hF);
    chk("w8_full_last", b_m_last, 1'b0);
    tick();

    // Random traffic against a packet-grouping model.
    src.delete(); exp_q.delete(); got_q.delete();
    for (int n = 0; n < 80; n++) begin
      sb.d = $urandom;
      sb.k = 4'($urandom_range(0, 15));
      sb.l = (n == 79) || ($urandom_range(0, 3) == 0);
      src.push_back(sb);
    end
    lane = 0; wd = '0; wk = '0;
    foreach (src[n]) begin
      wd[lane*32 +: 32] = src[n].d;
      wk[lane*4 +: 4]   = src[n].k;
      lane++;
      if (lane == 2 || src[n].l) begin
        exp_q.push_back({wd, wk, src[n].l});
        wd = '0; wk = '0; lane = 0;
      end
    end
    sent = 0; stab_err = 0;
    for (int c = 0; c < 3000 && sent < 80; c++) begin
      s_valid = ($urandom_range(0, 9) < 7);
      s_data = src[sent].d; s_keep = src[sent].k; s_last = src[sent].l;
      m_ready = ($urandom_range(0, 9) < 6);
      acc  = s_valid && s_ready;
      hold = m_valid && !m_ready;
      hd = m_data; hk = m_keep; hl = m_last;
      tick();
      if (acc) sent++;
      if (hold && (m_valid !== 1'b1 || m_data !== hd || m_keep !== hk || m_last !== hl)) stab_err++;
    end
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (6) tick();
    chk("rnd_all_sent", sent, 80);
    chk("rnd_stable", stab_err, 0);
    chk("rnd_count", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < got_q.size()) chk($sformatf("rnd_beat%0d", k), got_q[k], exp_q[k]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
